// File: rtl/tarot_card_drawer_if.sv
// rtl/tarot_card_drawer_if.sv - request, PRNG handshake and card output bundle for tarot_card_drawer
// master: the drawer itself; slave: the requester / PRNG side.
interface tarot_card_drawer_if;
  logic        draw_req;
  logic        prng_start;
  logic        prng_done;
  logic [31:0] prng_x;
  logic [31:0] prng_y;
  logic        card_valid;
  logic [6:0]  card_idx;
  logic        card_rev;
  logic [1:0]  card_pos;
  logic        spread_done;
  logic        busy;
  logic        err_timeout;

  modport master (
    input  draw_req, prng_done, prng_x, prng_y,
    output prng_start, card_valid, card_idx, card_rev, card_pos,
           spread_done, busy, err_timeout
  );

  modport slave (
    output draw_req, prng_done, prng_x, prng_y,
    input  prng_start, card_valid, card_idx, card_rev, card_pos,
           spread_done, busy, err_timeout
  );
endinterface

// File: rtl/tarot_card_drawer.sv
// rtl/tarot_card_drawer.sv - draws a duplicate-free tarot spread from PRNG words
// Each card: request a PRNG word, reduce its key mod NUM_CARDS bit-serially, probe past used cards.
module tarot_card_drawer #(
  parameter int NUM_CARDS    = 78,
  parameter int SPREAD_LEN   = 3,
  parameter int PRNG_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tarot_card_drawer_if.master  bus
);
  localparam int IW = $clog2(NUM_CARDS);
  localparam int CW = $clog2(PRNG_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_REDUCE, S_CHECK, S_EMIT
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_CARDS-1:0] used_q, used_d;
  logic [1:0]           pos_q, pos_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 done_prev_q;
  logic [15:0]          key_q, key_d;
  logic                 rev_q, rev_d;
  logic [7:0]           rem_q, rem_d;
  logic [3:0]           bit_q, bit_d;
  logic                 card_valid_q, card_valid_d;
  logic [6:0]           card_idx_q, card_idx_d;
  logic                 card_rev_q, card_rev_d;
  logic [1:0]           card_pos_q, card_pos_d;
  logic                 spread_done_q, spread_done_d;
  logic                 err_timeout_q, err_timeout_d;

  logic                 done_rise;
  logic [7:0]           rem_shift;
  logic [CW-1:0]        cnt_inc;
  logic [IW-1:0]        rem_idx;
  logic                 unused_prng_bits;

  assign unused_prng_bits = ^{bus.prng_x[31:16], bus.prng_y[15:0]};

  // A done level left high by an earlier run must not count as a fresh result.
  assign done_rise = bus.prng_done & ~done_prev_q;
  assign rem_shift = {rem_q[6:0], key_q[15]};
  assign cnt_inc   = cnt_q + 1'b1;
  assign rem_idx   = rem_q[IW-1:0];

  always_comb begin
    state_d       = state_q;
    used_d        = used_q;
    pos_d         = pos_q;
    cnt_d         = cnt_q;
    key_d         = key_q;
    rev_d         = rev_q;
    rem_d         = rem_q;
    bit_d         = bit_q;
    card_valid_d  = 1'b0;
    card_idx_d    = card_idx_q;
    card_rev_d    = card_rev_q;
    card_pos_d    = card_pos_q;
    spread_done_d = 1'b0;
    err_timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.draw_req) begin
          used_d  = '0;
          pos_d   = 2'd0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_rise) begin
          key_d   = bus.prng_x[15:0] ^ bus.prng_y[31:16];
          rev_d   = bus.prng_y[31];
          rem_d   = 8'd0;
          bit_d   = 4'd0;
          state_d = S_REDUCE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(PRNG_TIMEOUT)) begin
            err_timeout_d = 1'b1;
            state_d       = S_IDLE;
          end
        end
      end
      S_REDUCE: begin
        // Restoring remainder, one key bit per cycle, MSB first.
        rem_d = (rem_shift >= 8'(NUM_CARDS)) ? rem_shift - 8'(NUM_CARDS) : rem_shift;
        key_d = {key_q[14:0], 1'b0};
        bit_d = bit_q + 4'd1;
        if (bit_q == 4'd15) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (used_q[rem_idx]) begin
          rem_d = (rem_q == 8'(NUM_CARDS - 1)) ? 8'd0 : rem_q + 8'd1;
        end else begin
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        card_valid_d    = 1'b1;
        card_idx_d      = rem_q[6:0];
        card_rev_d      = rev_q;
        card_pos_d      = pos_q;
        used_d[rem_idx] = 1'b1;
        if (pos_q == 2'(SPREAD_LEN - 1)) begin
          spread_done_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          pos_d   = pos_q + 2'd1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      used_q        <= '0;
      pos_q         <= 2'd0;
      cnt_q         <= '0;
      done_prev_q   <= 1'b0;
      key_q         <= 16'd0;
      rev_q         <= 1'b0;
      rem_q         <= 8'd0;
      bit_q         <= 4'd0;
      card_valid_q  <= 1'b0;
      card_idx_q    <= 7'd0;
      card_rev_q    <= 1'b0;
      card_pos_q    <= 2'd0;
      spread_done_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      used_q        <= used_d;
      pos_q         <= pos_d;
      cnt_q         <= cnt_d;
      done_prev_q   <= bus.prng_done;
      key_q         <= key_d;
      rev_q         <= rev_d;
      rem_q         <= rem_d;
      bit_q         <= bit_d;
      card_valid_q  <= card_valid_d;
      card_idx_q    <= card_idx_d;
      card_rev_q    <= card_rev_d;
      card_pos_q    <= card_pos_d;
      spread_done_q <= spread_done_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign bus.prng_start  = (state_q == S_REQ);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.card_valid  = card_valid_q;
  assign bus.card_idx    = card_idx_q;
  assign bus.card_rev    = card_rev_q;
  assign bus.card_pos    = card_pos_q;
  assign bus.spread_done = spread_done_q;
  assign bus.err_timeout = err_timeout_q;
endmodule

// File: tb/tb_tarot_card_drawer.sv
// tb/tb_tarot_card_drawer.sv - bench for tarot_card_drawer with a behavioural PRNG and spread model
module tb_tarot_card_drawer;
  localparam int NC = 78;
  localparam int SL = 3;
  localparam int TO = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tarot_card_drawer_if bus ();

  tarot_card_drawer #(
    .NUM_CARDS(NC), .SPREAD_LEN(SL), .PRNG_TIMEOUT(TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // PRNG model: answers each start with the next queued word after its delay.
  logic [31:0] rsp_x [256];
  logic [31:0] rsp_y [256];
  int          rsp_d [256];
  int          rsp_wr = 0;
  int          rsp_rd = 0;
  int          pend = 0;
  logic [31:0] nx = '0, ny = '0;
  logic        done_drv = 1'b0;
  logic [31:0] x_drv = '0, y_drv = '0;
  int unsigned edge_cyc [256];
  int          edge_cnt = 0;
  int          start_cnt = 0;
  int unsigned start_cyc = 0;
  bit          hold_done = 1'b0;
  logic        draw_req_drv = 1'b0;

  assign bus.prng_done = done_drv;
  assign bus.prng_x    = x_drv;
  assign bus.prng_y    = y_drv;
  assign bus.draw_req  = draw_req_drv;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     = 0;
      rsp_rd   = rsp_wr;
      done_drv = 1'b0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          x_drv    = nx;
          y_drv    = ny;
          done_drv = 1'b1;
          edge_cyc[edge_cnt] = cyc + 1;
          edge_cnt++;
        end
      end
      if (bus.prng_start) begin
        start_cnt++;
        start_cyc = cyc;
        if (!hold_done) begin
          done_drv = 1'b0;
          nx       = rsp_x[rsp_rd];
          ny       = rsp_y[rsp_rd];
          pend     = rsp_d[rsp_rd];
          rsp_rd++;
        end
      end
    end
  end

  logic [6:0]  c_idx [256];
  logic        c_rev [256];
  logic [1:0]  c_pos [256];
  logic        c_sd  [256];
  int unsigned c_cyc [256];
  int          card_cnt = 0;
  int          sd_cnt = 0;
  int          err_cnt = 0;
  int unsigned err_cyc = 0;

  always @(negedge clk) begin
    if (bus.card_valid === 1'b1) begin
      c_idx[card_cnt] = bus.card_idx;
      c_rev[card_cnt] = bus.card_rev;
      c_pos[card_cnt] = bus.card_pos;
      c_sd[card_cnt]  = bus.spread_done;
      c_cyc[card_cnt] = cyc;
      card_cnt++;
    end
    if (bus.spread_done === 1'b1) sd_cnt++;
    if (bus.err_timeout === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic add_rsp(input logic [31:0] x, input logic [31:0] y, input int d);
    rsp_x[rsp_wr] = x;
    rsp_y[rsp_wr] = y;
    rsp_d[rsp_wr] = d;
    rsp_wr++;
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_prng_start"}, bus.prng_start, 0);
    chk({pfx, "_card_valid"}, bus.card_valid, 0);
    chk({pfx, "_card_idx"}, bus.card_idx, 0);
    chk({pfx, "_card_rev"}, bus.card_rev, 0);
    chk({pfx, "_card_pos"}, bus.card_pos, 0);
    chk({pfx, "_spread_done"}, bus.spread_done, 0);
    chk({pfx, "_busy"}, bus.busy, 0);
    chk({pfx, "_err_timeout"}, bus.err_timeout, 0);
  endtask

  task automatic pulse_draw();
    @(negedge clk);
    draw_req_drv = 1'b1;
    @(negedge clk);
    draw_req_drv = 1'b0;
  endtask

  // Expected spread: key % deck, walk forward past cards already dealt this spread.
  task automatic check_run(input int rb, input int cb, input int eb, input int sb);
    bit   used [NC];
    int   key, c, probes;
    for (int i = 0; i < NC; i++) used[i] = 1'b0;
    chk("n_cards", card_cnt - cb, SL);
    chk("n_starts", start_cnt - sb, SL);
    for (int k = 0; k < SL; k++) begin
      key    = int'(rsp_x[rb+k][15:0] ^ rsp_y[rb+k][31:16]);
      c      = key % NC;
      probes = 0;
      while (used[c]) begin
        c = (c + 1) % NC;
        probes++;
      end
      used[c] = 1'b1;
      if (card_cnt - cb > k) begin
        chk("card_idx", c_idx[cb+k], c);
        chk("card_rev", c_rev[cb+k], rsp_y[rb+k][31]);
        chk("card_pos", c_pos[cb+k], k);
        chk("spread_done", c_sd[cb+k], (k == SL - 1));
        chk("latency", c_cyc[cb+k] - edge_cyc[eb+k], 18 + probes);
      end
    end
  endtask

  task automatic run_spread(input bit poke);
    int rb, cb, eb, sb, n;
    rb = rsp_wr - SL;
    cb = card_cnt;
    eb = edge_cnt;
    sb = start_cnt;
    pulse_draw();
    if (poke) begin
      repeat (3) @(negedge clk);
      draw_req_drv = 1'b1;
      @(negedge clk);
      draw_req_drv = 1'b0;
      repeat (12) @(negedge clk);
      draw_req_drv = 1'b1;
      @(negedge clk);
      draw_req_drv = 1'b0;
    end
    n = 0;
    while (bus.busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("spread_bound", (n < 3000), 1);
    repeat (2) @(negedge clk);
    check_run(rb, cb, eb, sb);
  endtask

  initial begin
    int n, eb, cb, sb, sdb, erb;
    int unsigned e;
    logic [15:0] k;
    logic [31:0] y;

    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    // Same key three times: 58, then probes to 59 and 60.
    for (int i = 0; i < SL; i++) add_rsp(32'h0000_1234, 32'h0, 4);
    run_spread(1'b0);

    // 77 then wrap-around probes to 0 and 1.
    for (int i = 0; i < SL; i++) add_rsp(32'h0000_004D, 32'h0, 4);
    run_spread(1'b0);

    // Reversed card, key 0x1234 built from both words.
    for (int i = 0; i < SL; i++) add_rsp(32'h0000_9234, 32'h8000_0000, 3);
    run_spread(1'b0);

    // Requests while busy must be ignored.
    for (int i = 0; i < SL; i++) add_rsp(32'h0000_004D, 32'h8000_0000, 2);
    run_spread(1'b1);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < SL; i++) begin
        y = $urandom;
        if (r % 2 == 0) k = 16'($urandom_range(0, 77) + 78 * $urandom_range(0, 3));
        else            k = 16'($urandom);
        add_rsp({16'($urandom), k ^ y[31:16]}, y, $urandom_range(1, 12));
      end
      run_spread(r % 3 == 0);
    end

    // prng_done stays high from the last draw and never rises again.
    hold_done = 1'b1;
    cb  = card_cnt;
    sb  = start_cnt;
    sdb = sd_cnt;
    erb = err_cnt;
    pulse_draw();
    n = 0;
    while (err_cnt == erb && n < 1500) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_seen", err_cnt - erb, 1);
    chk("timeout_busy", bus.busy, 0);
    // REQ cycle, then TO cycles of WAIT before the pulse.
    chk("timeout_delay", err_cyc - start_cyc, TO + 1);
    chk("timeout_no_card", card_cnt - cb, 0);
    chk("timeout_no_done", sd_cnt - sdb, 0);
    chk("timeout_starts", start_cnt - sb, 1);
    hold_done = 1'b0;

    // Reset in the 8th REDUCE cycle of the first card.
    for (int i = 0; i < SL; i++) add_rsp($urandom, $urandom, 5);
    eb = edge_cnt;
    cb = card_cnt;
    pulse_draw();
    n = 0;
    while (edge_cnt == eb && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst_edge_seen", (edge_cnt > eb), 1);
    e = edge_cyc[eb];
    n = 0;
    while (cyc != e + 7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reduce_reached", (cyc == e + 7), 1);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    chk("rst_no_card", card_cnt - cb, 0);

    for (int i = 0; i < SL; i++) add_rsp($urandom, $urandom, $urandom_range(1, 8));
    run_spread(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
